// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes on the input side, holds results in a 2-entry skid buffer.
// Optional statistics counters are enabled by defining DECODE_STATS_EN.
module decode_stage #(
    parameter int XLEN = 32
`ifdef DECODE_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instruction_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instruction_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        fmt_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              illegal_o
`ifdef DECODE_STATS_EN
    ,
    output logic [CNT_W-1:0]  decoded_cnt_o,
    output logic [CNT_W-1:0]  illegal_cnt_o
`endif
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    state_t r_state;
    state_t w_nextState;
    dec_t   r_main;
    dec_t   r_skid;
    dec_t   w_dec;
    fmt_t   w_fmt;
    logic   w_bad;
    logic   w_illegal;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm32;
    logic   w_inFire;
    logic   w_outFire;
    logic   w_loadMain;
    logic   w_loadSkid;
    logic   w_mainFromSkid;

    assign w_opcode = instruction_i[6:0];
    assign w_funct3 = instruction_i[14:12];
    assign w_funct7 = instruction_i[31:25];

    // Classify the opcode and flag reserved funct encodings within each class.
    always_comb begin
        w_fmt = FMT_X;
        w_bad = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_fmt = FMT_R;
                w_bad = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) ||
                        (w_funct7 == 7'b0100000 && !(w_funct3 == 3'b000 || w_funct3 == 3'b101));
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    w_fmt = FMT_R;
                    w_bad = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) ||
                            (w_funct7 == 7'b0100000 && !(w_funct3 == 3'b000 || w_funct3 == 3'b101));
                end
            end
            7'b0010011, 7'b1110011, 7'b0001111: w_fmt = FMT_I;
            7'b0011011: begin
                if (XLEN == 64) w_fmt = FMT_I;
            end
            7'b0000011: begin
                w_fmt = FMT_I;
                w_bad = (w_funct3 == 3'b111) ||
                        (XLEN == 32 && (w_funct3 == 3'b011 || w_funct3 == 3'b110));
            end
            7'b1100111: begin
                w_fmt = FMT_I;
                w_bad = (w_funct3 != 3'b000);
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_bad = (XLEN == 32) ? (w_funct3 >= 3'b011) : (w_funct3 >= 3'b100);
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_bad = (w_funct3 == 3'b010 || w_funct3 == 3'b011);
            end
            7'b0110111, 7'b0010111: w_fmt = FMT_U;
            7'b1101111: w_fmt = FMT_J;
            default: w_fmt = FMT_X;
        endcase
    end

    assign w_illegal = (w_fmt == FMT_X) || w_bad || (instruction_i[1:0] != 2'b11);

    // Build the buffered record; unused fields and illegal encodings read as zero.
    always_comb begin
        w_dec   = '0;
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
            FMT_S: w_imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            FMT_B: w_imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                              instruction_i[30:25], instruction_i[11:8], 1'b0};
            FMT_U: w_imm32 = {instruction_i[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                              instruction_i[20], instruction_i[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
        w_dec.instr   = instruction_i;
        w_dec.pc      = pc_i;
        w_dec.fmt     = w_fmt;
        w_dec.illegal = w_illegal;
        if (!w_illegal) begin
            w_dec.imm = XLEN'($signed(w_imm32));
            if (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) w_dec.rs1 = instruction_i[19:15];
            if (w_fmt inside {FMT_R, FMT_S, FMT_B})        w_dec.rs2 = instruction_i[24:20];
            if (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) w_dec.rd  = instruction_i[11:7];
        end
    end

    assign out_valid_o = (r_state != ST_EMPTY);
    assign in_ready_o  = (r_state != ST_TWO);
    assign w_inFire    = in_valid_i & in_ready_o;
    assign w_outFire   = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_nextState;
    end

    // Occupancy transitions; flush wins over any transfer in the same cycle.
    always_comb begin
        w_nextState    = r_state;
        w_loadMain     = 1'b0;
        w_loadSkid     = 1'b0;
        w_mainFromSkid = 1'b0;
        if (flush_i) begin
            w_nextState = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inFire) begin
                        w_loadMain  = 1'b1;
                        w_nextState = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_inFire && w_outFire) begin
                        w_loadMain = 1'b1;
                    end else if (w_inFire) begin
                        w_loadSkid  = 1'b1;
                        w_nextState = ST_TWO;
                    end else if (w_outFire) begin
                        w_nextState = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_outFire) begin
                        w_mainFromSkid = 1'b1;
                        w_nextState    = ST_ONE;
                    end
                end
                default: w_nextState = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMain)          r_main <= w_dec;
            else if (w_mainFromSkid) r_main <= r_skid;
            if (w_loadSkid)          r_skid <= w_dec;
        end
    end

    assign instruction_o = r_main.instr;
    assign pc_o          = r_main.pc;
    assign rs1_o         = r_main.rs1;
    assign rs2_o         = r_main.rs2;
    assign rd_o          = r_main.rd;
    assign funct3_o      = r_main.instr[14:12];
    assign funct7_o      = r_main.instr[31:25];
    assign opcode_o      = r_main.instr[6:0];
    assign fmt_o         = r_main.fmt;
    assign imm_o         = r_main.imm;
    assign illegal_o     = r_main.illegal;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] r_decodedCnt;
    logic [CNT_W-1:0] r_illegalCnt;

    // Saturating counters of delivered and illegal instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decodedCnt <= '0;
            r_illegalCnt <= '0;
        end else if (w_outFire) begin
            if (r_decodedCnt != '1) r_decodedCnt <= r_decodedCnt + CNT_W'(1);
            if (r_main.illegal && r_illegalCnt != '1) r_illegalCnt <= r_illegalCnt + CNT_W'(1);
        end
    end

    assign decoded_cnt_o = r_decodedCnt;
    assign illegal_cnt_o = r_illegalCnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a FIFO-of-instructions reference model.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        inReady32, outValid32, illegal32;
    logic [31:0] instrO32, pcO32, imm32;
    logic [4:0]  rs1O32, rs2O32, rdO32;
    logic [2:0]  funct3O32, fmtO32;
    logic [6:0]  funct7O32, opcodeO32;

    logic        inReady64, outValid64, illegal64;
    logic [31:0] instrO64;
    logic [63:0] pcO64, imm64;
    logic [4:0]  rs1O64, rs2O64, rdO64;
    logic [2:0]  funct3O64, fmtO64;
    logic [6:0]  funct7O64, opcodeO64;

`ifdef DECODE_STATS_EN
    logic [31:0] decCnt32, illCnt32, decCnt64, illCnt64;
`endif

    int    checks = 0;
    int    errors = 0;
    logic  checkEn = 1'b0;
    item_t q[$];
    int    modelDec32 = 0, modelIll32 = 0, modelDec64 = 0, modelIll64 = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady32),
        .instruction_i(instr), .pc_i(pc[31:0]),
        .out_valid_o(outValid32), .out_ready_i(outReady),
        .instruction_o(instrO32), .pc_o(pcO32),
        .rs1_o(rs1O32), .rs2_o(rs2O32), .rd_o(rdO32),
        .funct3_o(funct3O32), .funct7_o(funct7O32), .opcode_o(opcodeO32),
        .fmt_o(fmtO32), .imm_o(imm32), .illegal_o(illegal32)
`ifdef DECODE_STATS_EN
        , .decoded_cnt_o(decCnt32), .illegal_cnt_o(illCnt32)
`endif
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady64),
        .instruction_i(instr), .pc_i(pc),
        .out_valid_o(outValid64), .out_ready_i(outReady),
        .instruction_o(instrO64), .pc_o(pcO64),
        .rs1_o(rs1O64), .rs2_o(rs2O64), .rd_o(rdO64),
        .funct3_o(funct3O64), .funct7_o(funct7O64), .opcode_o(opcodeO64),
        .fmt_o(fmtO64), .imm_o(imm64), .illegal_o(illegal64)
`ifdef DECODE_STATS_EN
        , .decoded_cnt_o(decCnt64), .illegal_cnt_o(illCnt64)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] p,
                                 input logic rdy, input logic fl);
        inValid  = v;
        instr    = ins;
        pc       = p;
        outReady = rdy;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sign-extend the low 'bits' bits of raw by plain arithmetic.
    function automatic longint sext(input longint raw, input int bits);
        longint v;
        v = raw;
        if (raw >= (longint'(1) <<< (bits - 1))) v = raw - (longint'(1) <<< bits);
        return v;
    endfunction

    function automatic exp_t refDecode(input logic [31:0] w, input int xlen);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        longint     imm;
        e  = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        imm = 0;
        if (op == 7'h33 || (xlen == 64 && op == 7'h3B)) e.fmt = 3'd0;
        else if ((op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) || (xlen == 64 && op == 7'h1B)) e.fmt = 3'd1;
        else if (op == 7'h23) e.fmt = 3'd2;
        else if (op == 7'h63) e.fmt = 3'd3;
        else if (op inside {7'h37, 7'h17}) e.fmt = 3'd4;
        else if (op == 7'h6F) e.fmt = 3'd5;
        else e.fmt = 3'd7;
        e.illegal = (e.fmt == 3'd7) || (w[1:0] != 2'b11)
                 || (e.fmt == 3'd0 && !(f7 inside {7'h00, 7'h20}))
                 || (e.fmt == 3'd0 && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))
                 || (op == 7'h03 && (f3 == 3'd7 || (xlen == 32 && (f3 inside {3'd3, 3'd6}))))
                 || (op == 7'h23 && int'(f3) >= ((xlen == 32) ? 3 : 4))
                 || (op == 7'h63 && (f3 inside {3'd2, 3'd3}))
                 || (op == 7'h67 && f3 != 3'd0);
        case (e.fmt)
            3'd1: imm = sext(longint'(w[31:20]), 12);
            3'd2: imm = sext(longint'({w[31:25], w[11:7]}), 12);
            3'd3: imm = sext(longint'({w[31], w[7], w[30:25], w[11:8]}) * 2, 13);
            3'd4: imm = sext(longint'(w[31:12]) * 4096, 32);
            3'd5: imm = sext(longint'({w[31], w[19:12], w[20], w[30:21]}) * 2, 21);
            default: imm = 0;
        endcase
        if (!e.illegal) begin
            e.imm = imm;
            if (e.fmt <= 3'd3) e.rs1 = w[19:15];
            if (e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) e.rs2 = w[24:20];
            if (e.fmt == 3'd0 || e.fmt == 3'd1 || e.fmt == 3'd4 || e.fmt == 3'd5) e.rd = w[11:7];
        end
        return e;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [14] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h3B, 7'h2B};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 15) != 0) w[6:0] = ops[$urandom_range(0, 13)];
        if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    always @(posedge rst) begin
        q.delete();
        modelDec32 = 0; modelIll32 = 0; modelDec64 = 0; modelIll64 = 0;
    end

    // Per-cycle comparison against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        exp_t  e32, e64;
        logic  inF, outF;
        if (!rst && checkEn) begin
            checkOutput("out_valid32", outValid32, q.size() > 0);
            checkOutput("out_valid64", outValid64, q.size() > 0);
            checkOutput("in_ready32", inReady32, q.size() < 2);
            checkOutput("in_ready64", inReady64, q.size() < 2);
            if (q.size() > 0) begin
                e32 = refDecode(q[0].instr, 32);
                e64 = refDecode(q[0].instr, 64);
                checkOutput("instr32", instrO32, q[0].instr);
                checkOutput("pc32", pcO32, q[0].pc[31:0]);
                checkOutput("fields32", {rs1O32, rs2O32, rdO32, fmtO32, illegal32},
                            {e32.rs1, e32.rs2, e32.rd, e32.fmt, e32.illegal});
                checkOutput("funct32", {funct3O32, funct7O32, opcodeO32},
                            {q[0].instr[14:12], q[0].instr[31:25], q[0].instr[6:0]});
                checkOutput("imm32", imm32, e32.imm[31:0]);
                checkOutput("instr64", instrO64, q[0].instr);
                checkOutput("pc64", pcO64, q[0].pc);
                checkOutput("fields64", {rs1O64, rs2O64, rdO64, fmtO64, illegal64},
                            {e64.rs1, e64.rs2, e64.rd, e64.fmt, e64.illegal});
                checkOutput("funct64", {funct3O64, funct7O64, opcodeO64},
                            {q[0].instr[14:12], q[0].instr[31:25], q[0].instr[6:0]});
                checkOutput("imm64", imm64, e64.imm);
            end
`ifdef DECODE_STATS_EN
            checkOutput("decoded_cnt32", decCnt32, modelDec32);
            checkOutput("illegal_cnt32", illCnt32, modelIll32);
            checkOutput("decoded_cnt64", decCnt64, modelDec64);
            checkOutput("illegal_cnt64", illCnt64, modelIll64);
`endif
            inF  = inValid && (q.size() < 2);
            outF = outReady && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (outF) begin
                    modelDec32++;
                    modelDec64++;
                    if (refDecode(q[0].instr, 32).illegal) modelIll32++;
                    if (refDecode(q[0].instr, 64).illegal) modelIll64++;
                    void'(q.pop_front());
                end
                if (inF) q.push_back({instr, pc});
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("reset out_valid", outValid32, 1'b0);
        checkOutput("reset in_ready", inReady32, 1'b1);
        checkOutput("reset payload", {instrO32, rdO32, fmtO32, illegal32}, 64'h0);
        checkOutput("reset imm64", imm64, 64'h0);
        checkEn = 1'b1;
        tick();

        // addi x1,x0,12
        applyStimulus(1'b1, 32'h00C00093, 64'h1000, 1'b1, 1'b0);
        tick();
        checkOutput("addi valid", outValid32, 1'b1);
        checkOutput("addi fmt/rs1/rs2/rd", {fmtO32, rs1O32, rs2O32, rdO32}, {3'd1, 5'd0, 5'd0, 5'd1});
        checkOutput("addi imm", imm32, 32'h0000000C);
        checkOutput("addi funct3/illegal", {funct3O32, illegal32}, {3'd0, 1'b0});

        // sw x2,8(x1) then lhu x2,12(x1)
        applyStimulus(1'b1, 32'h0020A423, 64'h1004, 1'b1, 1'b0);
        tick();
        checkOutput("sw fields", {fmtO32, rs1O32, rs2O32, rdO32}, {3'd2, 5'd1, 5'd2, 5'd0});
        checkOutput("sw imm", imm32, 32'h8);
        applyStimulus(1'b1, 32'h00C0D103, 64'h1008, 1'b1, 1'b0);
        tick();
        checkOutput("lhu fields", {fmtO32, rs1O32, rs2O32, rdO32, funct3O32}, {3'd1, 5'd1, 5'd0, 5'd2, 3'd5});
        checkOutput("lhu imm", imm32, 32'hC);

        // beq x1,x2,-4
        applyStimulus(1'b1, 32'hFE208EE3, 64'h100C, 1'b1, 1'b0);
        tick();
        checkOutput("beq fields64", {fmtO64, rs1O64, rs2O64, rdO64}, {3'd3, 5'd1, 5'd2, 5'd0});
        checkOutput("beq imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        checkOutput("beq imm32", imm32, 32'hFFFFFFFC);

        // illegal words are still delivered
        applyStimulus(1'b1, 32'h00000000, 64'h1010, 1'b1, 1'b0);
        tick();
        checkOutput("zero word", {outValid32, illegal32, fmtO32, rs1O32, rs2O32, rdO32},
                    {1'b1, 1'b1, 3'd7, 15'd0});
        checkOutput("zero word imm", imm64, 64'h0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 64'h1014, 1'b1, 1'b0);
        tick();
        checkOutput("ones word", {outValid64, illegal64, fmtO64, rs1O64, rs2O64, rdO64},
                    {1'b1, 1'b1, 3'd7, 15'd0});
        checkOutput("ones word imm", imm32, 32'h0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drained", outValid32, 1'b0);
`ifdef DECODE_STATS_EN
        checkOutput("stats decoded", decCnt32, 32'd6);
        checkOutput("stats illegal", illCnt64, 32'd2);
`endif

        // backpressure: four instructions with a three-cycle stall
        applyStimulus(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0);
        tick();
        checkOutput("stall A head", {inReady32, outValid32, instrO32}, {1'b1, 1'b1, 32'h00100093});
        applyStimulus(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0);
        tick();
        checkOutput("stall full", {inReady32, instrO32}, {1'b0, 32'h00100093});
        applyStimulus(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0);
        tick();
        checkOutput("stall hold", {inReady64, outValid64, instrO64}, {1'b0, 1'b1, 32'h00100093});
        applyStimulus(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
        tick();
        checkOutput("release B", {inReady32, instrO32}, {1'b1, 32'h00200113});
        tick();
        checkOutput("release C", instrO32, 32'h00300193);
        applyStimulus(1'b1, 32'h00400213, 64'h200C, 1'b1, 1'b0);
        tick();
        checkOutput("release D", instrO32, 32'h00400213);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("release empty", outValid32, 1'b0);

        // flush while full, with a concurrent input
        applyStimulus(1'b1, 32'h00500293, 64'h3000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00600313, 64'h3004, 1'b0, 1'b0);
        tick();
        checkOutput("pre-flush full", inReady32, 1'b0);
        applyStimulus(1'b1, 32'h00700393, 64'h3008, 1'b0, 1'b1);
        tick();
        checkOutput("flush", {outValid32, inReady32, outValid64, inReady64}, 4'b0101);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("post-flush", outValid32, 1'b0);

        // randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 70, randInstr(), {$urandom, $urandom},
                          (i % 200 < 100) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 30),
                          $urandom_range(0, 99) < 3);
            if (i == 1500) begin
                #1 rst = 1'b1;
                #1;
                checkOutput("async reset valid", {outValid32, outValid64}, 2'b00);
                checkOutput("async reset payload", {instrO32, imm64[31:0]}, 64'h0);
                #1 rst = 1'b0;
            end
            tick();
        end

        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        repeat (4) tick();
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Accepts a raw 32-bit instruction plus PC from fetch.
- Extracts register indices, funct fields, instruction format and a sign-extended XLEN immediate.
- Flags illegal encodings and presents the result to execute one cycle later.
- A 2-entry skid buffer sustains one instruction per cycle under downstream backpressure.
- Successor to the single-cycle combinational-index decoder: adds immediate generation, handshakes, flush and XLEN generalisation.

Parameters:
- XLEN, 32, datapath width for imm_o and pc; legal values 32 or 64.
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all buffered instructions.
- in_valid_i  in  1  instruction/PC valid.
- in_ready_o  out  1  stage can accept.
- instruction_i  in  32  raw instruction.
- pc_i  in  XLEN  instruction address.
- out_valid_o  out  1  decoded result valid.
- out_ready_i  in  1  execute accepts.
- instruction_o  out  32  raw instruction, passed through.
- pc_o  out  XLEN  PC, passed through.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- funct3_o  out  3  instr[14:12].
- funct7_o  out  7  instr[31:25].
- opcode_o  out  7  instr[6:0].
- fmt_o  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=invalid.
- imm_o  out  XLEN  sign-extended immediate.
- illegal_o  out  1  illegal encoding.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, except in_ready_o=1 once rst deasserts. Both buffer entries empty.
- Handshake and latency:
  - Input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
  - Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
  - Throughput is 1/cycle while out_ready_i=1.
- Buffer states: EMPTY → ONE on input only. ONE → TWO on input without output. TWO → ONE on output. ONE → EMPTY on output without input.
- in_ready_o = !(skid entry occupied). It is a registered signal, never combinational from out_ready_i.
- Ordering is strictly FIFO. Output payload must hold stable while out_valid_o=1 & out_ready_i=0.
- Decode is performed on the input side. The buffer stores decoded fields, so no output-side combinational decode.
- Opcode classes:
  - OP 0110011 = R.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011, FENCE 0001111 = I.
  - STORE 0100011 = S.
  - BRANCH 1100011 = B.
  - LUI 0110111, AUIPC 0010111 = U.
  - JAL 1101111 = J.
  - With XLEN=64, OP-IMM-32 0011011 = I and OP-32 0111011 = R.
  - Any other opcode: fmt=7, illegal=1.
- Unused register fields are forced to 0:
  - rs2_o=0 for I/U/J.
  - rs1_o=0 for U/J.
  - rd_o=0 for S/B.
  - All three are 0 when illegal.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: 0.
- Additional illegal conditions:
  - instr[1:0] != 2'b11.
  - R-type with funct7 not in {0000000, 0100000}.
  - funct7=0100000 with funct3 not in {000, 101}.
  - LOAD with funct3 in {011 (RV32 only), 110 (RV32 only), 111}.
  - STORE with funct3 ≥ 011 (RV32) or ≥ 100 (RV64).
  - BRANCH with funct3 in {010, 011}.
  - JALR with funct3 != 000.
- Illegal instructions are still passed downstream with illegal_o=1; they are never dropped.
- flush_i:
  - Takes effect at the next edge: both entries emptied, out_valid_o=0.
  - An input presented in the same cycle as flush_i is discarded.
  - flush_i has priority over all transfers.
- Reset mid-operation empties the buffer immediately (asynchronous). No partial outputs survive.

Optional Feature:
- Macro DECODE_STATS_EN.
- When defined, adds ports decoded_cnt_o [CNT_W] and illegal_cnt_o [CNT_W].
  - decoded_cnt_o increments on every output transfer; illegal_cnt_o increments on output transfers with illegal_o=1.
  - Both reset to 0 and saturate at all-ones.
  - Neither is affected by flush_i.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. addi x1,x0,12 (0x00C00093), out_ready_i=1 → next cycle: out_valid_o=1, fmt=1, rs1=0, rs2=0, rd=1, funct3=000, imm=0x0000000C, illegal=0.
2. sw x2,8(x1) (0x0020A423) then lhu x2,12(x1) (0x00C0D103) back-to-back → S: rs1=1, rs2=2, rd=0, imm=8. Then I: rs1=1, rd=2, funct3=101, imm=12. One per cycle.
3. beq x1,x2,-4 (0xFE208EE3) with XLEN=64 → fmt=3, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFFFFFFFFFC.
4. 0x00000000 and 0xFFFFFFFF → fmt=7, illegal=1, rs1/rs2/rd/imm all 0, still delivered. With DECODE_STATS_EN: illegal_cnt_o=2.
5. Stream 4 instructions, hold out_ready_i=0 for 3 cycles:
   - in_ready_o drops after 2 accepts and payload stays stable.
   - On release, all 4 emerge in order with no loss or duplication.
6. Buffer full (TWO) with flush_i=1 plus a concurrent input → next cycle: out_valid_o=0, in_ready_o=1, and none of the 3 instructions ever appear. Asserting rst mid-stream clears the outputs asynchronously.
